// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared frame constants, sample conversion and FSM state type for the I2S transmitter
package i2s_pkg;

  localparam int FRAME_BITS = 32;
  localparam int SLOT_W     = 5;
  localparam int SAMPLE_W   = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Offset-binary to two's complement: flipping the MSB maps mid-scale 0x7FFF to -1 (0xFFFF).
  function automatic logic [SAMPLE_W-1:0] to_twos(input logic [SAMPLE_W-1:0] s);
    return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// rtl/i2s_clkgen.sv - BCLK divider with a one-cycle strobe on the clk edge where BCLK falls
module i2s_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bclk,
  output logic fall_stb
);

  logic [7:0] r_div;
  logic       r_bclk;
  logic       w_wrap;

  assign w_wrap   = (r_div == 8'(CLK_DIV - 1));
  assign bclk     = r_bclk;
  // High-to-low toggle happens on the clk edge where this is 1.
  assign fall_stb = run & w_wrap & r_bclk;

  // Half-period counter; idle holds BCLK low with the count at zero so each run starts from a full low phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div  <= '0;
      r_bclk <= 1'b0;
    end else if (!run) begin
      r_div  <= '0;
      r_bclk <= 1'b0;
    end else if (w_wrap) begin
      r_div  <= '0;
      r_bclk <= ~r_bclk;
    end else begin
      r_div  <= r_div + 8'd1;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - mono-duplicated I2S transmitter with one-entry sample buffer and sticky underrun flag
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  i2s_bclk,
  output logic                  i2s_lrck,
  output logic                  i2s_sdata,
  output logic                  underrun
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_run;
  logic                  w_fall;
  logic                  w_xfer;
  logic                  w_load;
  logic                  w_stop;
  logic [SLOT_W-1:0]     r_slot;
  logic [SLOT_W-1:0]     w_slot_nxt;
  logic [DATA_WIDTH-1:0] r_buf;
  logic [DATA_WIDTH-1:0] r_last;
  logic [DATA_WIDTH-1:0] w_conv;
  logic [DATA_WIDTH-1:0] w_word;
  logic [FRAME_BITS-1:0] w_frame;
  logic [FRAME_BITS-1:0] r_shift;
  logic                  r_full;
  logic                  r_lrck;
  logic                  r_sdata;
  logic                  r_underrun;

  assign w_run      = (r_state == ST_RUN);
  assign w_conv     = to_twos(sample_in);
  assign w_xfer     = sample_valid & ~r_full;
  assign w_slot_nxt = r_slot + SLOT_W'(1);
  // Falling edge leaving slot 0 enters slot 1: that is where a new frame word is taken.
  assign w_load     = w_fall & (r_slot == '0);
  assign w_stop     = w_fall & (r_slot == SLOT_W'(FRAME_BITS - 1)) & ~enable;
  // Buffered word first, else a same-edge transfer, else repeat the previous word.
  assign w_word     = r_full ? r_buf : (w_xfer ? w_conv : r_last);
  assign w_frame    = {w_word, w_word};

  assign sample_ready = ~r_full;
  assign i2s_lrck     = r_lrck;
  assign i2s_sdata    = r_sdata;
  assign underrun     = r_underrun;

  i2s_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk      (clk),
    .rst      (rst),
    .run      (w_run),
    .bclk     (i2s_bclk),
    .fall_stb (w_fall)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Start immediately on enable; stop only once slot 31 has been fully sent.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (enable) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_stop) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // One-entry holding buffer; the load edge always drains it, even if a transfer lands on that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 1'b0;
      r_buf  <= '0;
      r_last <= '0;
    end else if (w_load) begin
      r_full <= 1'b0;
      r_last <= w_word;
    end else if (w_xfer) begin
      r_full <= 1'b1;
      r_buf  <= w_conv;
    end
  end

  // Sticky underrun: a frame started with nothing new to send.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_underrun <= 1'b0;
    else if (w_load && !r_full && !w_xfer) r_underrun <= 1'b1;
  end

  // Slot counter and serializer; outputs move only on BCLK falling edges and the MSB lands one slot late.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot  <= '0;
      r_shift <= '0;
      r_lrck  <= 1'b0;
      r_sdata <= 1'b0;
    end else if (!w_run) begin
      r_slot  <= '0;
      r_lrck  <= 1'b0;
      r_sdata <= 1'b0;
    end else if (w_fall) begin
      r_slot <= w_slot_nxt;
      if (w_stop) begin
        r_lrck  <= 1'b0;
        r_sdata <= 1'b0;
      end else begin
        r_lrck <= w_slot_nxt[SLOT_W-1];
        if (w_load) begin
          r_shift <= w_frame;
          r_sdata <= w_frame[FRAME_BITS-1];
        end else begin
          r_shift <= r_shift << 1;
          r_sdata <= r_shift[FRAME_BITS-2];
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// tb/tb_i2s_tx.sv - randomized self-checking bench for i2s_tx against a frame-level reference model
module tb_i2s_tx;

  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic        i2s_bclk;
  logic        i2s_lrck;
  logic        i2s_sdata;
  logic        underrun;

  i2s_tx #(
    .DATA_WIDTH (16),
    .CLK_DIV    (CLK_DIV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_sdata    (i2s_sdata),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] src_q[$];
  logic [15:0] mq[$];
  logic [15:0] last_w = '0;
  logic        exp_unr = 1'b0;
  logic [31:0] exp_frame = '0;
  logic [31:0] cap_d = '0;
  logic [31:0] cap_l = '0;
  logic [2:0]  idle_or;
  int tb_slot = 0, gap = 0, hi_cnt = 0, fall_cnt = 0, frames_done = 0, ready_rises = 0, feed_mode = 0;
  int r0, f0;
  bit active = 0, first_fall = 0, have_frame = 0, stopping = 0, fell_now = 0;
  bit prev_bclk = 0, prev_ready = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic handle_fall();
    logic [15:0] w;
    logic [31:0] expf;
    logic [4:0]  idx;
    tb_slot = (tb_slot + 1) % 32;
    if (first_fall) check("first_fall_latency", 32'(gap), 32'(2 * CLK_DIV + 1));
    else            check("bclk_period", 32'(gap), 32'(2 * CLK_DIV));
    first_fall = 0;
    gap = 0;
    if (tb_slot == 1) begin
      if (mq.size() > 0) w = mq.pop_front();
      else begin
        w = last_w;
        exp_unr = 1'b1;
      end
      last_w = w;
      exp_frame = {w, w};
      cap_d = '0;
      cap_l = '0;
      have_frame = 1;
    end
    idx = (tb_slot == 0) ? 5'd0 : 5'(32 - tb_slot);
    cap_d[idx] = i2s_sdata;
    cap_l[5'(tb_slot)] = i2s_lrck;
    if (tb_slot == 0 && have_frame) begin
      expf = exp_frame;
      if (stopping) expf[0] = 1'b0;
      check("frame_data", cap_d, expf);
      check("lrck_pattern", cap_l, 32'hFFFF_0000);
      frames_done++;
      have_frame = 0;
      if (stopping) active = 0;
    end
  endtask

  task automatic step();
    logic [15:0] v;
    bit is_fall;
    @(negedge clk);
    gap++;
    fell_now = 0;
    is_fall = prev_bclk && (i2s_bclk === 1'b0);
    if (i2s_bclk === 1'b1) hi_cnt++;
    else hi_cnt = 0;
    prev_bclk = (i2s_bclk === 1'b1);
    if (is_fall) begin
      fall_cnt++;
      fell_now = 1;
      if (active) handle_fall();
    end
    if (sample_ready === 1'b1 && !prev_ready) ready_rises++;
    prev_ready = (sample_ready === 1'b1);
    check("sample_ready", 32'(sample_ready), 32'(mq.size() == 0));
    check("underrun", 32'(underrun), 32'(exp_unr));
    sample_valid = 1'b0;
    sample_in = 16'($urandom);
    if (!rst && src_q.size() > 0 && mq.size() == 0 &&
        (feed_mode == 1 || (feed_mode == 2 && tb_slot == 0 && hi_cnt == CLK_DIV))) begin
      v = src_q.pop_front();
      sample_in = v;
      sample_valid = 1'b1;
      mq.push_back(v ^ 16'h8000);
    end
  endtask

  task automatic start_run();
    enable = 1'b1;
    active = 1;
    tb_slot = 0;
    gap = 0;
    first_fall = 1;
    have_frame = 0;
    stopping = 0;
  endtask

  task automatic run_frames(input int n);
    int target;
    target = frames_done + n;
    for (int i = 0; i < n * 300 + 100 && frames_done < target; i++) step();
    check("frames_reached", 32'(frames_done), 32'(target));
  endtask

  task automatic run_until_slot(input int s);
    bit hit;
    hit = 0;
    for (int i = 0; i < 800 && !hit; i++) begin
      step();
      hit = fell_now && active && (tb_slot == s);
    end
    check("slot_reached", 32'(hit), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    sample_valid = 1'b0;
    sample_in = '0;

    repeat (3) step();
    check("rst_bclk", 32'(i2s_bclk), 32'd0);
    check("rst_lrck", 32'(i2s_lrck), 32'd0);
    check("rst_sdata", 32'(i2s_sdata), 32'd0);
    check("rst_ready", 32'(sample_ready), 32'd1);
    check("rst_underrun", 32'(underrun), 32'd0);
    rst = 1'b0;

    // Handshake while idle: preload mid-scale, serial lines stay quiet.
    src_q.push_back(16'h7FFF);
    feed_mode = 1;
    idle_or = '0;
    repeat (20) begin
      step();
      idle_or |= {i2s_bclk, i2s_lrck, i2s_sdata};
    end
    check("idle_quiet", 32'(idle_or), 32'd0);

    // Directed extremes followed by 256 random table values, one per frame.
    src_q.push_back(16'h0000);
    src_q.push_back(16'hFFFF);
    for (int i = 0; i < 256; i++) src_q.push_back(16'($urandom));
    r0 = ready_rises;
    start_run();
    run_frames(259);
    check("ready_pulses", 32'(ready_rises - r0), 32'd259);
    check("no_underrun", 32'(underrun), 32'd0);

    // Single sample then starvation: word repeats and underrun sticks.
    src_q.push_back(16'h1234);
    run_frames(2);
    check("underrun_sticky", 32'(underrun), 32'd1);

    // Transfer landing exactly on the load edge.
    feed_mode = 2;
    src_q.push_back(16'($urandom));
    run_frames(2);

    // Stop request in slot 5: frame completes, then idle.
    feed_mode = 1;
    src_q.push_back(16'($urandom));
    src_q.push_back(16'($urandom));
    run_until_slot(5);
    enable = 1'b0;
    stopping = 1;
    f0 = fall_cnt;
    for (int i = 0; i < 400 && active; i++) step();
    check("stop_done", 32'(active), 32'd0);
    idle_or = '0;
    repeat (64) begin
      step();
      idle_or |= {i2s_bclk, i2s_lrck, i2s_sdata};
    end
    check("stop_idle_quiet", 32'(idle_or), 32'd0);
    check("stop_falls", 32'(fall_cnt - f0), 32'd27);

    // Restart, then asynchronous reset in slot 10.
    src_q.push_back(16'($urandom));
    start_run();
    run_until_slot(10);
    #2 rst = 1'b1;
    #1;
    check("arst_bclk", 32'(i2s_bclk), 32'd0);
    check("arst_lrck", 32'(i2s_lrck), 32'd0);
    check("arst_sdata", 32'(i2s_sdata), 32'd0);
    check("arst_ready", 32'(sample_ready), 32'd1);
    check("arst_underrun", 32'(underrun), 32'd0);
    mq.delete();
    src_q.delete();
    last_w = '0;
    exp_unr = 1'b0;
    active = 0;
    sample_valid = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    start_run();
    src_q.push_back(16'($urandom));
    src_q.push_back(16'($urandom));
    run_frames(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
